// File: rtl/clk_ctrl_pkg.sv
// rtl/clk_ctrl_pkg.sv - shared state encoding and ratio helpers for the clock-divider controller
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    localparam int unsigned MIN_DIV = 2;

    function automatic logic [31:0] clamp_div(input logic [31:0] n);
        return (n < MIN_DIV) ? 32'(MIN_DIV) : n;
    endfunction

    // High phase is the larger half so odd ratios get ceil(N/2) high cycles.
    function automatic logic [31:0] high_len(input logic [31:0] n);
        return (n + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/div_phase_counter.sv
// rtl/div_phase_counter.sv - phase counter with registered div_clk/tick for the next-cycle ratio
module div_phase_counter
    import clk_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] ratio_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             div_clk_o,
    output logic             tick_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] high_w;
    logic             div_clk_q, div_clk_d;
    logic             tick_q, tick_d;

    assign high_w = CNT_W'(high_len(32'(ratio_i)));

    // run_i/load_i/ratio_i describe the coming cycle, so the output flops
    // always agree with the cnt value they are registered alongside.
    always_comb begin
        cnt_d = cnt_q + ONE;
        if (!run_i || load_i || (cnt_q >= (ratio_i - ONE))) begin
            cnt_d = '0;
        end
        div_clk_d = run_i && (cnt_d < high_w);
        tick_d    = run_i && (cnt_d == '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            div_clk_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_clk_q <= div_clk_d;
            tick_q    <= tick_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign div_clk_o = div_clk_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - programmable divider controller; ratio/enable changes land on period boundaries
module clk_div_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_en,
    output logic             div_clk,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] cur_div
);

    localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(clamp_div(32'(DEFAULT_DIV)));
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic [CNT_W-1:0] sh_div_q, sh_div_d;
    logic             sh_en_q, sh_en_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cfg_div_clamped;
    logic             accept;
    logic             at_end;
    logic             load;
    logic             run;

    assign cfg_ready       = (state_q != PEND);
    assign busy            = (state_q == PEND);
    assign accept          = cfg_valid && cfg_ready;
    assign cfg_div_clamped = CNT_W'(clamp_div(32'(cfg_div)));
    assign at_end          = (cnt == (cur_div_q - ONE));

    always_comb begin
        state_d   = state_q;
        cur_div_d = cur_div_q;
        sh_div_d  = sh_div_q;
        sh_en_d   = sh_en_q;
        load      = 1'b0;
        if (accept) begin
            sh_div_d = cfg_div_clamped;
            sh_en_d  = cfg_en;
        end
        case (state_q)
            STOP: begin
                if (accept) begin
                    cur_div_d = cfg_div_clamped;
                    if (cfg_en) begin
                        state_d = RUN;
                        load    = 1'b1;
                    end
                end
            end
            RUN: begin
                // A request arriving on the last cycle skips PEND entirely.
                if (accept) begin
                    if (at_end) begin
                        cur_div_d = cfg_div_clamped;
                        state_d   = cfg_en ? RUN : STOP;
                        load      = cfg_en;
                    end else begin
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                if (at_end) begin
                    cur_div_d = sh_div_q;
                    state_d   = sh_en_q ? RUN : STOP;
                    load      = sh_en_q;
                end
            end
            default: state_d = STOP;
        endcase
        run = (state_d != STOP);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= STOP;
            cur_div_q <= RESET_DIV;
            sh_div_q  <= '0;
            sh_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_div_q <= cur_div_d;
            sh_div_q  <= sh_div_d;
            sh_en_q   <= sh_en_d;
        end
    end

    div_phase_counter #(
        .CNT_W(CNT_W)
    ) u_phase (
        .clock    (clock),
        .reset    (reset),
        .run_i    (run),
        .load_i   (load),
        .ratio_i  (cur_div_d),
        .cnt_o    (cnt),
        .div_clk_o(div_clk),
        .tick_o   (tick)
    );

    assign cur_div = cur_div_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - table-driven self-checking bench for clk_div_ctrl
module tb_clk_div_ctrl;

    logic       clock;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_div;
    logic       cfg_en;
    logic       div_clk;
    logic       tick;
    logic       busy;
    logic [7:0] cur_div;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       e;
        logic       dc;
        logic       tk;
        logic       rdy;
        logic       bsy;
        logic [7:0] cd;
    } row_t;

    row_t rows[$];

    clk_div_ctrl #(
        .CNT_W      (8),
        .DEFAULT_DIV(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_div  (cfg_div),
        .cfg_en   (cfg_en),
        .div_clk  (div_clk),
        .tick     (tick),
        .busy     (busy),
        .cur_div  (cur_div)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic e,
                       input logic dc, input logic tk, input logic rdy, input logic bsy,
                       input logic [7:0] cd);
        row_t r;
        r.v = v; r.d = d; r.e = e;
        r.dc = dc; r.tk = tk; r.rdy = rdy; r.bsy = bsy; r.cd = cd;
        rows.push_back(r);
    endtask

    // Each row: outputs expected during a cycle, and inputs presented in it.
    task automatic run_rows();
        for (int i = 0; i < rows.size(); i++) begin
            @(negedge clock);
            chk("div_clk",   i, 32'(div_clk),   32'(rows[i].dc));
            chk("tick",      i, 32'(tick),      32'(rows[i].tk));
            chk("cfg_ready", i, 32'(cfg_ready), 32'(rows[i].rdy));
            chk("busy",      i, 32'(busy),      32'(rows[i].bsy));
            chk("cur_div",   i, 32'(cur_div),   32'(rows[i].cd));
            cfg_valid = rows[i].v;
            cfg_div   = rows[i].d;
            cfg_en    = rows[i].e;
        end
        rows.delete();
    endtask

    initial begin
        reset     = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 8'd0;
        cfg_en    = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_div_clk", -1, 32'(div_clk),   0);
        chk("rst_tick",    -1, 32'(tick),      0);
        chk("rst_busy",    -1, 32'(busy),      0);
        chk("rst_ready",   -1, 32'(cfg_ready), 1);
        chk("rst_cur_div", -1, 32'(cur_div),   4);
        reset = 1'b1;

        // N=4 run, stop request, N=3, clamp N=1 at boundary, mid-period N=6 with held N=8
        add(1,4,1, 0,0,1,0,4);
        add(0,0,0, 1,1,1,0,4);
        add(0,0,0, 1,0,1,0,4);
        add(0,0,0, 0,0,1,0,4);
        add(0,0,0, 0,0,1,0,4);
        add(0,0,0, 1,1,1,0,4);
        add(0,0,0, 1,0,1,0,4);
        add(0,0,0, 0,0,1,0,4);
        add(0,0,0, 0,0,1,0,4);
        add(1,4,0, 1,1,1,0,4);
        add(0,0,0, 1,0,0,1,4);
        add(0,0,0, 0,0,0,1,4);
        add(0,0,0, 0,0,0,1,4);
        add(0,0,0, 0,0,1,0,4);
        add(1,3,1, 0,0,1,0,4);
        add(0,0,0, 1,1,1,0,3);
        add(0,0,0, 1,0,1,0,3);
        add(1,1,1, 0,0,1,0,3);
        add(0,0,0, 1,1,1,0,2);
        add(0,0,0, 0,0,1,0,2);
        add(0,0,0, 1,1,1,0,2);
        add(1,4,1, 0,0,1,0,2);
        add(0,0,0, 1,1,1,0,4);
        add(1,6,1, 1,0,1,0,4);
        add(1,8,1, 0,0,0,1,4);
        add(1,8,1, 0,0,0,1,4);
        add(1,8,1, 1,1,1,0,6);
        add(0,0,0, 1,0,0,1,6);
        add(0,0,0, 1,0,0,1,6);
        add(0,0,0, 0,0,0,1,6);
        add(0,0,0, 0,0,0,1,6);
        add(0,0,0, 0,0,0,1,6);
        add(0,0,0, 1,1,1,0,8);
        add(0,0,0, 1,0,1,0,8);
        add(0,0,0, 1,0,1,0,8);
        add(0,0,0, 1,0,1,0,8);
        add(0,0,0, 0,0,1,0,8);
        add(0,0,0, 0,0,1,0,8);
        add(0,0,0, 0,0,1,0,8);
        add(0,0,0, 0,0,1,0,8);
        add(1,5,1, 1,1,1,0,8);
        add(0,0,0, 1,0,0,1,8);
        run_rows();

        // Asynchronous reset while PEND with div_clk high, away from any clock edge
        #2 reset = 1'b0;
        #1;
        chk("async_div_clk", -2, 32'(div_clk),   0);
        chk("async_busy",    -2, 32'(busy),      0);
        chk("async_tick",    -2, 32'(tick),      0);
        chk("async_ready",   -2, 32'(cfg_ready), 1);
        chk("async_cur_div", -2, 32'(cur_div),   4);
        @(negedge clock);
        chk("held_div_clk",  -3, 32'(div_clk),   0);
        reset = 1'b1;

        // Stop-mode apply of clamped N=0, then N=5 and a same-ratio re-apply
        add(1,0,0, 0,0,1,0,4);
        add(1,5,1, 0,0,1,0,2);
        add(0,0,0, 1,1,1,0,5);
        add(0,0,0, 1,0,1,0,5);
        add(0,0,0, 1,0,1,0,5);
        add(0,0,0, 0,0,1,0,5);
        add(0,0,0, 0,0,1,0,5);
        add(1,5,1, 1,1,1,0,5);
        add(0,0,0, 1,0,0,1,5);
        add(0,0,0, 1,0,0,1,5);
        add(0,0,0, 0,0,0,1,5);
        add(0,0,0, 0,0,0,1,5);
        add(0,0,0, 1,1,1,0,5);
        add(0,0,0, 1,0,1,0,5);
        run_rows();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
